enemy_motion: RTL and testbench

ENEMY_MOTION -- requirements
Module: enemy_motion

---
 rtl/enemy_motion_if.sv | 20 ++
 rtl/enemy_motion.sv | 184 ++++++++++++++++++
 tb/tb_enemy_motion.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_motion_if.sv
// Entity-side bus for one enemy: motion/combat commands in, position and visibility out.
interface enemy_motion_if;
  logic       frame_clk;
  logic [1:0] dir;
  logic       spawn;
  logic       hit;
  logic [9:0] Enemy_X;
  logic [9:0] Enemy_Y;
  logic       Enemy_Active;

  modport master (
    output frame_clk, dir, spawn, hit,
    input  Enemy_X, Enemy_Y, Enemy_Active
  );

  modport slave (
    input  frame_clk, dir, spawn, hit,
    output Enemy_X, Enemy_Y, Enemy_Active
  );
endinterface

// File: rtl/enemy_motion.sv
// Frame-stepped enemy mover: spawn, walk, knockback when hurt, timed respawn after death.
module enemy_motion #(
  parameter int unsigned SPAWN_X        = 320,
  parameter int unsigned SPAWN_Y        = 240,
  parameter int unsigned STEP           = 1,
  parameter int unsigned KNOCK          = 4,
  parameter int unsigned X_MIN          = 16,
  parameter int unsigned X_MAX          = 608,
  parameter int unsigned Y_MIN          = 16,
  parameter int unsigned Y_MAX          = 448,
  parameter int unsigned HP_INIT        = 3,
  parameter int unsigned HURT_FRAMES    = 8,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input logic           clk,
  input logic           reset_n,
  enemy_motion_if.slave bus
);

  localparam int unsigned CNT_MAX = (RESPAWN_FRAMES > HURT_FRAMES) ? RESPAWN_FRAMES : HURT_FRAMES;
  localparam int unsigned CW      = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [10:0] X_LO    = 11'(X_MIN);
  localparam logic [10:0] X_HI    = 11'(X_MAX);
  localparam logic [10:0] Y_LO    = 11'(Y_MIN);
  localparam logic [10:0] Y_HI    = 11'(Y_MAX);
  localparam logic [10:0] STEP_A  = 11'(STEP);
  localparam logic [10:0] KNOCK_A = 11'(KNOCK);
  localparam logic [9:0]  SX      = 10'(SPAWN_X);
  localparam logic [9:0]  SY      = 10'(SPAWN_Y);
  localparam logic [1:0]  HP_V    = 2'(HP_INIT);

  typedef enum logic [1:0] {
    ST_INACTIVE,
    ST_ALIVE,
    ST_HURT,
    ST_RESPAWN
  } state_e;

  state_e        state_q, state_d;
  logic          fs1_q, fs1_d, fs2_q, fs2_d, hist_q, hist_d;
  logic          fill_q, fill_d, armed_q, armed_d;
  logic          pend_q, pend_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    hp_q, hp_d, head_q, head_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          tick, hit_now;

  function automatic logic [9:0] inc_clamp(input logic [9:0] pos, input logic [10:0] amt,
                                           input logic [10:0] hi);
    logic [10:0] sum;
    sum = {1'b0, pos} + amt;
    return 10'((sum > hi) ? hi : sum);
  endfunction

  function automatic logic [9:0] dec_clamp(input logic [9:0] pos, input logic [10:0] amt,
                                           input logic [10:0] lo);
    logic [10:0] diff;
    diff = {1'b0, pos} - amt;
    return 10'((diff[10] || (diff < lo)) ? lo : diff);
  endfunction

  function automatic logic [19:0] move(input logic [9:0] x, input logic [9:0] y,
                                       input logic [1:0] head, input logic [10:0] amt);
    logic [9:0] nx, ny;
    nx = x;
    ny = y;
    case (head)
      2'd0:    ny = dec_clamp(y, amt, Y_LO);
      2'd1:    nx = inc_clamp(x, amt, X_HI);
      2'd2:    ny = inc_clamp(y, amt, Y_HI);
      default: nx = dec_clamp(x, amt, X_LO);
    endcase
    return {nx, ny};
  endfunction

  // armed_q only rises once the first synchronizer stage has really sampled frame_clk low,
  // so a strobe already high when reset releases never produces a tick.
  assign tick    = fs2_q & ~hist_q & armed_q;
  assign hit_now = pend_q | bus.hit;

  always_comb begin
    fs1_d    = bus.frame_clk;
    fs2_d    = fs1_q;
    hist_d   = fs2_q;
    fill_d   = 1'b1;
    armed_d  = armed_q | (fill_q & ~fs1_q);
    pend_d   = tick ? 1'b0 : hit_now;
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    case (state_q)
      ST_INACTIVE: begin
        if (bus.spawn) begin
          state_d = ST_ALIVE;
          x_d     = SX;
          y_d     = SY;
          hp_d    = HP_V;
        end
      end
      ST_ALIVE: begin
        if (tick) begin
          if (hit_now) begin
            hp_d = hp_q - 2'd1;
            if (hp_q <= 2'd1) begin
              state_d = ST_RESPAWN;
              cnt_d   = CW'(RESPAWN_FRAMES);
            end else begin
              state_d = ST_HURT;
              cnt_d   = CW'(HURT_FRAMES);
              head_d  = bus.dir ^ 2'd2;
            end
          end else begin
            {x_d, y_d} = move(x_q, y_q, bus.dir, STEP_A);
          end
        end
      end
      ST_HURT: begin
        if (tick) begin
          {x_d, y_d} = move(x_q, y_q, head_q, KNOCK_A);
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (tick) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
            x_d     = SX;
            y_d     = SY;
            hp_d    = HP_V;
          end
        end
      end
    endcase
    active_d = (state_d == ST_ALIVE) || (state_d == ST_HURT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs1_q    <= 1'b0;
      fs2_q    <= 1'b0;
      hist_q   <= 1'b0;
      fill_q   <= 1'b0;
      armed_q  <= 1'b0;
      pend_q   <= 1'b0;
      state_q  <= ST_INACTIVE;
      x_q      <= SX;
      y_q      <= SY;
      hp_q     <= HP_V;
      cnt_q    <= '0;
      head_q   <= '0;
      active_q <= 1'b0;
    end else begin
      fs1_q    <= fs1_d;
      fs2_q    <= fs2_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      armed_q  <= armed_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      active_q <= active_d;
    end
  end

  assign bus.Enemy_X      = x_q;
  assign bus.Enemy_Y      = y_q;
  assign bus.Enemy_Active = active_q;

endmodule

// File: tb/tb_enemy_motion.sv
// Bench for enemy_motion: directed scenarios plus randomized frames against a frame-level model.
module tb_enemy_motion;

  localparam int SX = 320, SY = 240, XMIN = 16, XMAX = 608, YMIN = 16, YMAX = 448;
  localparam int HPI = 3, HURTF = 8, RESPF = 60, STEPV = 1, KNOCKV = 4;
  localparam int M_IDLE = 0, M_ALIVE = 1, M_HURT = 2, M_DEAD = 3;

  logic clk = 1'b0;
  logic reset_n;

  enemy_motion_if bus();

  enemy_motion #(
    .SPAWN_X(SX), .SPAWN_Y(SY), .STEP(STEPV), .KNOCK(KNOCKV),
    .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .HP_INIT(HPI), .HURT_FRAMES(HURTF), .RESPAWN_FRAMES(RESPF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_x, m_y, m_hp, m_left, m_head;
  bit m_pend;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_x"}, int'(bus.Enemy_X), m_x);
    check_val({tag, "_y"}, int'(bus.Enemy_Y), m_y);
    check_val({tag, "_active"}, int'(bus.Enemy_Active),
              (m_mode == M_ALIVE || m_mode == M_HURT) ? 1 : 0);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = SX; m_y = SY; m_hp = HPI; m_left = 0; m_head = 0; m_pend = 0;
  endtask

  task automatic model_spawn();
    m_mode = M_ALIVE; m_x = SX; m_y = SY; m_hp = HPI;
  endtask

  task automatic model_move(input int h, input int amt);
    case (h)
      0: m_y = clampi(m_y - amt, YMIN, YMAX);
      1: m_x = clampi(m_x + amt, XMIN, XMAX);
      2: m_y = clampi(m_y + amt, YMIN, YMAX);
      default: m_x = clampi(m_x - amt, XMIN, XMAX);
    endcase
  endtask

  // One frame's worth of game rules, applied when the frame strobe is recognised.
  task automatic model_frame(input bit h, input int d);
    if (m_mode == M_ALIVE) begin
      if (h) begin
        m_hp--;
        if (m_hp == 0) begin m_mode = M_DEAD; m_left = RESPF; end
        else begin m_mode = M_HURT; m_left = HURTF; m_head = (d + 2) % 4; end
      end else model_move(d, STEPV);
    end else if (m_mode == M_HURT) begin
      model_move(m_head, KNOCKV);
      m_left--;
      if (m_left == 0) m_mode = M_ALIVE;
    end else if (m_mode == M_DEAD) begin
      m_left--;
      if (m_left == 0) model_spawn();
    end
  endtask

  // Each frame is six clocks; the strobe rises at cycle 0 and is recognised on the edge closing cycle 2.
  task automatic run_frame(input logic [1:0] d, input logic [5:0] hm, input int sc);
    bit h;
    check_outputs("frame");
    for (int c = 0; c < 6; c++) begin
      bus.frame_clk = (c < 3);
      bus.dir       = d;
      bus.hit       = hm[c];
      bus.spawn     = (c == sc);
      if (c == 2) begin
        h = m_pend | hm[c];
        m_pend = 0;
        if (m_mode == M_IDLE) begin
          if (c == sc) model_spawn();
        end else model_frame(h, int'(d));
      end else begin
        m_pend = m_pend | hm[c];
        if (c == sc && m_mode == M_IDLE) model_spawn();
      end
      @(negedge clk);
    end
    bus.hit   = 1'b0;
    bus.spawn = 1'b0;
  endtask

  task automatic do_reset(input logic fc);
    reset_n = 1'b0;
    bus.frame_clk = fc; bus.hit = 1'b0; bus.spawn = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0] rdir;
    logic [5:0] hm;
    int sc;

    reset_n = 1'b0;
    bus.frame_clk = 1'b0; bus.dir = 2'd0; bus.spawn = 1'b0; bus.hit = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("reset_x", int'(bus.Enemy_X), 320);
    check_val("reset_y", int'(bus.Enemy_Y), 240);
    check_val("reset_active", int'(bus.Enemy_Active), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spawn and walk right for ten frames.
    run_frame(2'd1, 6'b0, 0);
    repeat (9) run_frame(2'd1, 6'b0, -1);
    check_val("walk_x", int'(bus.Enemy_X), 330);
    check_val("walk_y", int'(bus.Enemy_Y), 240);
    check_val("walk_active", int'(bus.Enemy_Active), 1);

    repeat (400) run_frame(2'd3, 6'b0, -1);
    check_val("clamp_xmin", int'(bus.Enemy_X), 16);
    repeat (300) run_frame(2'd0, 6'b0, -1);
    check_val("clamp_ymin", int'(bus.Enemy_Y), 16);
    check_val("clamp_hold_x", int'(bus.Enemy_X), 16);

    // Knockback: hit on the first tick after spawn, hit again while invulnerable.
    do_reset(1'b0);
    run_frame(2'd1, 6'b000010, 0);
    check_val("hurt_entry_x", int'(bus.Enemy_X), 320);
    for (int i = 0; i < 8; i++) run_frame(2'd1, (i == 2) ? 6'b000001 : 6'b0, -1);
    check_val("knock_x", int'(bus.Enemy_X), 288);
    run_frame(2'd1, 6'b0, -1);
    check_val("alive_again_x", int'(bus.Enemy_X), 289);

    // Hit on the tick cycle plus another before the next tick costs one hp.
    run_frame(2'd1, 6'b010100, -1);
    check_val("double_hit_x", int'(bus.Enemy_X), 289);
    repeat (8) run_frame(2'd1, 6'b0, -1);
    check_val("knock2_x", int'(bus.Enemy_X), 257);
    check_val("knock2_active", int'(bus.Enemy_Active), 1);
    run_frame(2'd1, 6'b000001, -1);
    check_val("dead_active", int'(bus.Enemy_Active), 0);
    for (int i = 0; i < 59; i++) run_frame(2'd1, 6'b0, (i % 10 == 0) ? 4 : -1);
    check_val("wait_active", int'(bus.Enemy_Active), 0);
    run_frame(2'd1, 6'b0, -1);
    check_val("respawn_x", int'(bus.Enemy_X), 320);
    check_val("respawn_y", int'(bus.Enemy_Y), 240);
    check_val("respawn_active", int'(bus.Enemy_Active), 1);

    // Full hp restored: two hits survive, the third kills.
    run_frame(2'd1, 6'b000001, -1);
    repeat (8) run_frame(2'd1, 6'b0, 2);
    run_frame(2'd1, 6'b000001, 0);
    repeat (8) run_frame(2'd1, 6'b0, -1);
    check_val("two_hits_active", int'(bus.Enemy_Active), 1);
    run_frame(2'd1, 6'b000001, -1);
    check_val("third_hit_active", int'(bus.Enemy_Active), 0);
    repeat (10) run_frame(2'd2, 6'b0, -1);

    // Asynchronous reset in the middle of the respawn wait.
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_x", int'(bus.Enemy_X), 320);
    check_val("async_rst_y", int'(bus.Enemy_Y), 240);
    check_val("async_rst_active", int'(bus.Enemy_Active), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    repeat (65) run_frame(2'd1, 6'b0, -1);
    check_val("no_respawn_active", int'(bus.Enemy_Active), 0);

    // Strobe already high at reset release must not tick.
    reset_n = 1'b0;
    bus.frame_clk = 1'b1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.dir = 2'd1; bus.spawn = 1'b1;
    @(negedge clk);
    bus.spawn = 1'b0;
    model_spawn();
    repeat (5) @(negedge clk);
    check_val("stale_high_x", int'(bus.Enemy_X), 320);
    check_val("stale_high_active", int'(bus.Enemy_Active), 1);
    bus.frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(2'd1, 6'b0, -1);
    check_val("fresh_edge_x", int'(bus.Enemy_X), 321);

    rdir = 2'd0;
    for (int f = 0; f < 800; f++) begin
      if ($urandom_range(0, 39) == 0) rdir = 2'($urandom_range(0, 3));
      hm = '0;
      for (int c = 0; c < 6; c++) if ($urandom_range(0, 29) == 0) hm[c] = 1'b1;
      sc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      if ($urandom_range(0, 299) == 0) do_reset(1'b0);
      run_frame(rdir, hm, sc);
    end
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
